// File: rtl/mole_timer_pkg.sv
// Shared level codes and the level -> lifetime lookup for the mole timers.
package mole_timer_pkg;

    localparam logic [1:0] LVL_EASY   = 2'd0;
    localparam logic [1:0] LVL_MED    = 2'd1;
    localparam logic [1:0] LVL_HARD   = 2'd2;
    localparam logic [1:0] LVL_EXPERT = 2'd3;

    function automatic int unsigned level_ticks(
        input logic [1:0]  lvl,
        input int unsigned easy,
        input int unsigned med,
        input int unsigned hard,
        input int unsigned expert
    );
        case (lvl)
            LVL_EASY: return easy;
            LVL_MED:  return med;
            LVL_HARD: return hard;
            default:  return expert;
        endcase
    endfunction

endpackage

// File: rtl/mole_chan_timer.sv
// One mole channel: lifetime counter, latched limit, live flag and the hit/miss/timeout pulses.
module mole_chan_timer
    import mole_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_game,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tick,
    input  logic             start,
    input  logic             hit,
    input  logic [CNT_W-1:0] lim_in,
    output logic             active,
    output logic             active_nxt,
    output logic             timeout_pulse,
    output logic             hit_pulse,
    output logic             miss_pulse
);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] lim, lim_nxt;
    logic [CNT_W-1:0] last_cnt;
    logic             to_nxt, hp_nxt, mp_nxt;

    always_comb begin
        cnt_nxt    = cnt;
        lim_nxt    = lim;
        active_nxt = active;
        to_nxt     = 1'b0;
        hp_nxt     = 1'b0;
        mp_nxt     = 1'b0;
        // lim is never 0 for a live mole, guard only keeps the subtraction well-defined
        last_cnt   = (lim == '0) ? '0 : lim - CNT_W'(1);
        if (!enable) begin
            cnt_nxt    = '0;
            active_nxt = 1'b0;
        end else if (start) begin
            cnt_nxt    = '0;
            lim_nxt    = lim_in;
            active_nxt = 1'b1;
        end else if (hit) begin
            if (active) begin
                active_nxt = 1'b0;
                cnt_nxt    = '0;
                hp_nxt     = 1'b1;
            end else begin
                mp_nxt = 1'b1;
            end
        end else if (active && tick) begin
            if (cnt >= last_cnt) begin
                active_nxt = 1'b0;
                cnt_nxt    = '0;
                to_nxt     = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_game) begin
        if (!rst_n) begin
            cnt           <= '0;
            lim           <= '0;
            active        <= 1'b0;
            timeout_pulse <= 1'b0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            lim           <= lim_nxt;
            active        <= active_nxt;
            timeout_pulse <= to_nxt;
            hit_pulse     <= hp_nxt;
            miss_pulse    <= mp_nxt;
        end
    end

endmodule

// File: rtl/multi_mole_timer.sv
// N_MOLES independent mole lifetime timers sharing one level-derived limit and an active popcount.
// Optional hit-driven speedup of new moles: define MOLE_TIMER_SPEEDUP_EN.
module multi_mole_timer
    import mole_timer_pkg::*;
#(
    parameter int N_MOLES          = 8,
    parameter int CNT_W            = 8,
    parameter int LED_TICKS_EASY   = 10,
    parameter int LED_TICKS_MED    = 7,
    parameter int LED_TICKS_HARD   = 4,
    parameter int LED_TICKS_EXPERT = 2
`ifdef MOLE_TIMER_SPEEDUP_EN
    ,
    parameter int SPEEDUP_STEP     = 5,
    parameter int MIN_TICKS        = 1
`endif
) (
    input  logic                         clk_game,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         tick,
    input  logic [1:0]                   level,
    input  logic [N_MOLES-1:0]           start,
    input  logic [N_MOLES-1:0]           hit,
    output logic [N_MOLES-1:0]           active,
    output logic [N_MOLES-1:0]           timeout_pulse,
    output logic [N_MOLES-1:0]           hit_pulse,
    output logic [N_MOLES-1:0]           miss_pulse,
    output logic [$clog2(N_MOLES+1)-1:0] n_active
);

    localparam int NA_W = $clog2(N_MOLES + 1);

    function automatic logic [NA_W-1:0] popcount(input logic [N_MOLES-1:0] v);
        logic [NA_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_MOLES; i++) c = c + NA_W'(v[i]);
        return c;
    endfunction

    logic [CNT_W-1:0]   base_lim;
    logic [CNT_W-1:0]   eff_raw;
    logic [CNT_W-1:0]   chan_lim;
    logic [N_MOLES-1:0] active_nxt;

    always_comb base_lim = CNT_W'(level_ticks(level, LED_TICKS_EASY, LED_TICKS_MED,
                                              LED_TICKS_HARD, LED_TICKS_EXPERT));

`ifdef MOLE_TIMER_SPEEDUP_EN
    localparam int HACC_W = $clog2(SPEEDUP_STEP + N_MOLES + 1);

    logic [CNT_W-1:0]  offset;
    logic [HACC_W-1:0] hit_acc;
    logic [HACC_W-1:0] acc_sum;
    logic [CNT_W:0]    off_sum;
    logic [CNT_W-1:0]  diff;

    // Registered hit pulses feed the counter, so a new offset is seen by starts one cycle later
    always_comb begin
        acc_sum = hit_acc + HACC_W'(popcount(hit_pulse));
        off_sum = {1'b0, offset} + (CNT_W+1)'(acc_sum / HACC_W'(SPEEDUP_STEP));
    end

    always_ff @(posedge clk_game) begin
        if (!rst_n || !enable) begin
            offset  <= '0;
            hit_acc <= '0;
        end else begin
            hit_acc <= acc_sum % HACC_W'(SPEEDUP_STEP);
            offset  <= off_sum[CNT_W] ? '1 : off_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        diff = base_lim - offset;
        if (base_lim > offset && diff >= CNT_W'(MIN_TICKS)) eff_raw = diff;
        else                                                 eff_raw = CNT_W'(MIN_TICKS);
    end
`else
    always_comb eff_raw = base_lim;
`endif

    always_comb chan_lim = (eff_raw == '0) ? CNT_W'(1) : eff_raw;

    for (genvar g = 0; g < N_MOLES; g++) begin : g_chan
        mole_chan_timer #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_game      (clk_game),
            .rst_n         (rst_n),
            .enable        (enable),
            .tick          (tick),
            .start         (start[g]),
            .hit           (hit[g]),
            .lim_in        (chan_lim),
            .active        (active[g]),
            .active_nxt    (active_nxt[g]),
            .timeout_pulse (timeout_pulse[g]),
            .hit_pulse     (hit_pulse[g]),
            .miss_pulse    (miss_pulse[g])
        );
    end

    always_ff @(posedge clk_game) begin
        if (!rst_n) n_active <= '0;
        else        n_active <= popcount(active_nxt);
    end

endmodule

// File: tb/tb_multi_mole_timer.sv
// Bench for multi_mole_timer: vector table, hand sequences and random stimulus against a lifetime model.
module tb_multi_mole_timer;

    localparam int N    = 8;
    localparam int NA_W = $clog2(N + 1);

    logic            clk_game = 1'b0;
    logic            rst_n, enable, tick;
    logic [1:0]      level;
    logic [N-1:0]    start, hit;
    logic [N-1:0]    active, timeout_pulse, hit_pulse, miss_pulse;
    logic [NA_W-1:0] n_active;

    int total = 0;
    int bad   = 0;

    multi_mole_timer dut (
        .clk_game      (clk_game),
        .rst_n         (rst_n),
        .enable        (enable),
        .tick          (tick),
        .level         (level),
        .start         (start),
        .hit           (hit),
        .active        (active),
        .timeout_pulse (timeout_pulse),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .n_active      (n_active)
    );

    always #5 clk_game = ~clk_game;

    // Model: each live mole holds the number of ticks it has left to live
    bit       m_live [N];
    int       m_rem  [N];
    logic [N-1:0] e_act, e_to, e_hp, e_mp;
    int       e_n;
`ifdef MOLE_TIMER_SPEEDUP_EN
    int m_off = 0, m_acc = 0, m_pend = 0;
`endif

    function automatic int lim_of(input logic [1:0] l);
        int t;
        case (l)
            2'd0:    t = 10;
            2'd1:    t = 7;
            2'd2:    t = 4;
            default: t = 2;
        endcase
        t = t % 256;
`ifdef MOLE_TIMER_SPEEDUP_EN
        t = t - m_off;
        if (t < 1) t = 1;
`endif
        if (t == 0) t = 1;
        return t;
    endfunction

    task automatic model_step();
        e_to = '0; e_hp = '0; e_mp = '0;
        if (!rst_n || !enable) begin
            for (int i = 0; i < N; i++) m_live[i] = 0;
`ifdef MOLE_TIMER_SPEEDUP_EN
            m_off = 0; m_acc = 0; m_pend = 0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                if (start[i]) begin
                    m_live[i] = 1;
                    m_rem[i]  = lim_of(level);
                end else if (hit[i]) begin
                    if (m_live[i]) begin
                        m_live[i] = 0;
                        e_hp[i]   = 1'b1;
                    end else begin
                        e_mp[i] = 1'b1;
                    end
                end else if (m_live[i] && tick) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_live[i] = 0;
                        e_to[i]   = 1'b1;
                    end
                end
            end
`ifdef MOLE_TIMER_SPEEDUP_EN
            m_acc  = m_acc + m_pend;
            m_off  = m_off + m_acc / 5;
            m_acc  = m_acc % 5;
            if (m_off > 255) m_off = 255;
            m_pend = $countones(e_hp);
`endif
        end
        e_n = 0;
        for (int i = 0; i < N; i++) begin
            e_act[i] = m_live[i];
            e_n += int'(m_live[i]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk_game);
        #1;
        chk("active",  32'(active),        32'(e_act));
        chk("timeout", 32'(timeout_pulse), 32'(e_to));
        chk("hitp",    32'(hit_pulse),     32'(e_hp));
        chk("missp",   32'(miss_pulse),    32'(e_mp));
        chk("n_active", 32'(n_active),     32'(e_n));
    endtask

    // Start channel 0 and count cycles until its timeout pulse
    task automatic measure(input logic [1:0] lvl, output int cyc);
        level = lvl; start = 8'h01; hit = '0; tick = 1'b1;
        step();
        start = '0;
        cyc = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (timeout_pulse[0]) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            total++; bad++;
            $display("FAIL timeout_wait: got no timeout expected one within 300 cycles");
        end
    endtask

    task automatic do_hits(input int n);
        for (int k = 0; k < n; k++) begin
            start = 8'h01; hit = '0; step();
            start = '0;    hit = 8'h01; step();
            hit = '0;
        end
    endtask

    typedef struct {
        logic         tk;
        logic [1:0]   lvl;
        logic [N-1:0] st, ht;
        logic [N-1:0] e_act, e_to, e_hp, e_mp;
        int           e_n;
    } vec_t;

    function automatic vec_t mkv(input logic tk, input logic [1:0] lvl, input logic [N-1:0] st, ht,
                                 input logic [N-1:0] a, t, h, m, input int n);
        vec_t v;
        v.tk = tk; v.lvl = lvl; v.st = st; v.ht = ht;
        v.e_act = a; v.e_to = t; v.e_hp = h; v.e_mp = m; v.e_n = n;
        return v;
    endfunction

    vec_t vt [18];
    int   cyc;

    initial begin
        vt[0]  = mkv(1, 0, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 1);
        vt[1]  = mkv(1, 0, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 1);
        vt[2]  = mkv(1, 0, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 1);
        vt[3]  = mkv(1, 0, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 0);
        vt[4]  = mkv(1, 0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 0);
        vt[5]  = mkv(1, 3, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1);
        vt[6]  = mkv(1, 3, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1);
        vt[7]  = mkv(1, 3, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 0);
        vt[8]  = mkv(1, 3, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1);
        vt[9]  = mkv(1, 3, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1);
        vt[10] = mkv(1, 3, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1);
        vt[11] = mkv(1, 3, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1);
        vt[12] = mkv(1, 3, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 0);
        vt[13] = mkv(1, 3, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        vt[14] = mkv(0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        vt[15] = mkv(1, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        vt[16] = mkv(0, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        vt[17] = mkv(1, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 0);

        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; level = 2'd0; start = '0; hit = '0;
        step(); step();
        chk("rst_active", 32'(active), 0);
        chk("rst_n_active", 32'(n_active), 0);
        rst_n = 1'b1; enable = 1'b1;
        step();

        // Lifetime at level 0 and n_active rise/fall
        measure(2'd0, cyc);
        chk("life_easy", cyc, 10);
        chk("n_after_expiry", 32'(n_active), 0);
        level = 2'd0; start = 8'h01; step(); start = '0;
        chk("n_one_live", 32'(n_active), 1);
        hit = 8'h01; step(); hit = '0;

        for (int v = 0; v < 18; v++) begin
            tick = vt[v].tk; level = vt[v].lvl; start = vt[v].st; hit = vt[v].ht;
            step();
            chk($sformatf("vec%0d_active", v),  32'(active),        32'(vt[v].e_act));
            chk($sformatf("vec%0d_timeout", v), 32'(timeout_pulse), 32'(vt[v].e_to));
            chk($sformatf("vec%0d_hitp", v),    32'(hit_pulse),     32'(vt[v].e_hp));
            chk($sformatf("vec%0d_missp", v),   32'(miss_pulse),    32'(vt[v].e_mp));
            chk($sformatf("vec%0d_n", v),       32'(n_active),      32'(vt[v].e_n));
        end
        start = '0; hit = '0; tick = 1'b1;

        // All channels live, then enable drop, then reset mid-life
        start = 8'hFF; step(); start = '0;
        chk("all_n", 32'(n_active), 8);
        step(); step();
        enable = 1'b0; step();
        chk("dis_active", 32'(active), 0);
        chk("dis_n", 32'(n_active), 0);
        chk("dis_pulses", 32'(timeout_pulse | hit_pulse | miss_pulse), 0);
        enable = 1'b1; start = 8'hFF; step(); start = '0; step();
        rst_n = 1'b0; step();
        chk("midrst_active", 32'(active), 0);
        chk("midrst_n", 32'(n_active), 0);
        chk("midrst_pulses", 32'(timeout_pulse | hit_pulse | miss_pulse), 0);
        rst_n = 1'b1; step();

        // Hit-driven speedup of subsequent moles
        enable = 1'b0; step(); enable = 1'b1; step();
        do_hits(5); step(); step();
        measure(2'd0, cyc);
`ifdef MOLE_TIMER_SPEEDUP_EN
        chk("life_after5", cyc, 9);
`else
        chk("life_after5", cyc, 10);
`endif
        do_hits(45); step(); step();
        measure(2'd0, cyc);
`ifdef MOLE_TIMER_SPEEDUP_EN
        chk("life_after50", cyc, 1);
`else
        chk("life_after50", cyc, 10);
`endif

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 79) != 0);
            tick   = ($urandom_range(0, 3) != 0);
            level  = 2'($urandom_range(0, 3));
            start  = N'($urandom & $urandom & $urandom);
            hit    = N'($urandom & $urandom & $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
